// File: rtl/board_fetch_arbiter.sv
// board_fetch_arbiter
//   Owns the single port of the 81-cell Sudoku board RAM. Once per scanline,
//   at the start of horizontal blanking, it reads the 9 cells of the grid row
//   that the next line will display into a line buffer. When no fetch is in
//   progress it grants one-cycle writes from the solver/recognizer. The
//   display outputs (in_grid, index, number) follow h_cnt/v_cnt by one clk.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   h_cnt, v_cnt         VGA counters (h_cnt may hold for several clks)
//   wr_req/wr_index/     write request, held until wr_ack; dropped the
//   wr_number/wr_ack     cycle after the one-cycle wr_ack pulse
//   mem_addr/mem_we/     board RAM port; mem_rdata is valid one clk after
//   mem_wdata/mem_rdata  the address it belongs to
//   in_grid/index/number pixel-side cell information (registered)
//   fetch_busy           high while fetching or draining the last read
//   fsm_state            current FSM state, for debug/observation
//
// Handshake: wr_req is a level request held by the requester. A write is
// accepted in the cycle wr_ack is high (exactly one cycle); the requester
// must not change wr_index/wr_number while wr_req is high and unacknowledged.
module board_fetch_arbiter #(
  parameter int CELL_SIZE = 52,
  parameter int GRID_N    = 9,
  parameter int H_ACTIVE  = 640,
  parameter int V_TOTAL   = 525,
  parameter int NUM_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic             wr_req,
  input  logic [6:0]       wr_index,
  input  logic [NUM_W-1:0] wr_number,
  output logic             wr_ack,
  output logic [6:0]       mem_addr,
  output logic             mem_we,
  output logic [NUM_W-1:0] mem_wdata,
  input  logic [NUM_W-1:0] mem_rdata,
  output logic             in_grid,
  output logic [9:0]       index,
  output logic [NUM_W-1:0] number,
  output logic             fetch_busy,
  output logic [1:0]       fsm_state
);

  localparam int GRID_PX = GRID_N * CELL_SIZE;
  localparam int CELLS   = GRID_N * GRID_N;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

  state_t           state, next_state;
  logic [9:0]       h_prev;
  logic             pending;
  logic [3:0]       pend_row;
  logic [3:0]       fetch_row;
  logic [3:0]       k;
  logic             buf_valid;
  logic [NUM_W-1:0] buf_mem [GRID_N];

  logic             trig;
  logic [9:0]       target_line;
  logic             trig_fetch;
  logic [3:0]       trig_row;
  logic             fetch_req;
  logic [3:0]       start_row;
  logic             start_fetch;
  logic             do_write;
  logic [3:0]       col;
  logic [3:0]       row;
  logic             pix_in_grid;

  assign fsm_state = state;

  // Edge detect on h_cnt reaching the blanking start, so a held h_cnt value
  // produces a single trigger per line.
  assign trig        = (h_cnt == 10'(H_ACTIVE)) && (h_prev != 10'(H_ACTIVE));
  assign target_line = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
  assign trig_fetch  = trig && (target_line < 10'(GRID_PX));
  assign trig_row    = 4'(target_line / 10'(CELL_SIZE));
  assign fetch_req   = pending || trig_fetch;
  // A fresh trigger names the line actually coming next, so it wins over
  // an older pending row.
  assign start_row   = trig_fetch ? trig_row : pend_row;

  assign pix_in_grid = (h_cnt < 10'(GRID_PX)) && (v_cnt < 10'(GRID_PX));
  assign col         = 4'(h_cnt / 10'(CELL_SIZE));
  assign row         = 4'(v_cnt / 10'(CELL_SIZE));

  always_comb begin
    next_state  = state;
    start_fetch = 1'b0;
    do_write    = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          next_state  = FETCH;
          start_fetch = 1'b1;
        end else if (wr_req) begin
          next_state = WRITE;
          do_write   = 1'b1;
        end
      end
      FETCH: begin
        if (k == 4'(GRID_N - 1)) next_state = DRAIN;
      end
      DRAIN: next_state = IDLE;
      WRITE: begin
        // A trigger that arrived during the write starts the fetch right away.
        if (fetch_req) begin
          next_state  = FETCH;
          start_fetch = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      h_prev     <= '0;
      pending    <= 1'b0;
      pend_row   <= '0;
      fetch_row  <= '0;
      k          <= '0;
      buf_valid  <= 1'b0;
      for (int i = 0; i < GRID_N; i++) buf_mem[i] <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      wr_ack     <= 1'b0;
      in_grid    <= 1'b0;
      index      <= '0;
      number     <= '0;
      fetch_busy <= 1'b0;
    end else begin
      state  <= next_state;
      h_prev <= h_cnt;
      mem_we <= 1'b0;
      wr_ack <= 1'b0;

      if (start_fetch) begin
        pending <= 1'b0;
      end else if (trig_fetch) begin
        pending  <= 1'b1;
        pend_row <= trig_row;
      end

      if (start_fetch) begin
        fetch_row <= start_row;
        k         <= '0;
        mem_addr  <= 7'(start_row) * 7'(GRID_N);
      end else if (state == FETCH) begin
        // Read data in this cycle belongs to the address issued last cycle.
        if (k != 4'd0) buf_mem[k - 4'd1] <= mem_rdata;
        if (k != 4'(GRID_N - 1)) begin
          k        <= k + 4'd1;
          mem_addr <= 7'(fetch_row) * 7'(GRID_N) + 7'(k) + 7'd1;
        end
      end else if (state == DRAIN) begin
        buf_mem[GRID_N-1] <= mem_rdata;
        buf_valid         <= 1'b1;
      end

      if (do_write) begin
        mem_addr  <= wr_index;
        mem_wdata <= wr_number;
        mem_we    <= (wr_index < 7'(CELLS));
        wr_ack    <= 1'b1;
      end

      fetch_busy <= (next_state == FETCH) || (next_state == DRAIN);

      in_grid <= pix_in_grid;
      if (pix_in_grid) begin
        index  <= 10'(row) * 10'(GRID_N) + 10'(col);
        number <= buf_valid ? buf_mem[col] : '0;
      end else begin
        index  <= '0;
        number <= '0;
      end
    end
  end

endmodule

// File: tb/tb_board_fetch_arbiter.sv
module tb_board_fetch_arbiter;

  localparam int NUM_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             wr_req;
  logic [6:0]       wr_index;
  logic [NUM_W-1:0] wr_number;
  logic             wr_ack;
  logic [6:0]       mem_addr;
  logic             mem_we;
  logic [NUM_W-1:0] mem_wdata;
  logic [NUM_W-1:0] mem_rdata;
  logic             in_grid;
  logic [9:0]       index;
  logic [NUM_W-1:0] number;
  logic             fetch_busy;
  logic [1:0]       fsm_state;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  board_fetch_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .wr_req     (wr_req),
    .wr_index   (wr_index),
    .wr_number  (wr_number),
    .wr_ack     (wr_ack),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .in_grid    (in_grid),
    .index      (index),
    .number     (number),
    .fetch_busy (fetch_busy),
    .fsm_state  (fsm_state)
  );

  // Board RAM model: synchronous read, one clk latency.
  logic [NUM_W-1:0] ram [128];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [9:0]       h;
    logic [9:0]       v;
    logic             exp_in;
    logic [9:0]       exp_idx;
    logic [NUM_W-1:0] exp_num;
  } vec_t;
  vec_t vecs [8];

  // ---------------- driver / checker tasks ----------------
  // One cycle = posedge to posedge; outputs are sampled and inputs driven
  // 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Trigger the hblank of line v and check the 9 addresses plus drain timing.
  task automatic fetch_line(input int v, input int base);
    tick(); h_cnt = 10'd639; v_cnt = 10'(v);
    tick(); h_cnt = 10'd640;
    for (int n = 0; n < 9; n++) begin
      tick();
      chk($sformatf("fetch_addr v%0d k%0d", v, n), mem_addr, base + n);
      chk("fetch_busy_fetch", fetch_busy, 1);
      chk("fetch_no_we", mem_we, 0);
    end
    tick(); chk("fetch_busy_drain", fetch_busy, 1);
    tick(); chk("fetch_busy_idle", fetch_busy, 0);
  endtask

  task automatic show_pixel(input int h, input int v, input int e_in, input int e_idx,
                            input int e_num);
    h_cnt = 10'(h); v_cnt = 10'(v);
    tick();
    chk($sformatf("in_grid h%0d v%0d", h, v), in_grid, e_in);
    chk($sformatf("index h%0d v%0d", h, v), index, e_idx);
    chk($sformatf("number h%0d v%0d", h, v), number, e_num);
  endtask

  task automatic do_write(input int idx, input int num, input int exp_we);
    tick(); wr_req = 1'b1; wr_index = 7'(idx); wr_number = NUM_W'(num);
    tick();
    chk("wr_ack_pulse", wr_ack, 1);
    chk("wr_we", mem_we, exp_we);
    chk("wr_addr", mem_addr, idx);
    if (exp_we == 1) chk("wr_wdata", mem_wdata, num);
    tick(); wr_req = 1'b0;
    chk("wr_ack_single", wr_ack, 0);
    chk("wr_we_single", mem_we, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < 128; i++) ram[i] = NUM_W'(i + 1);
    vecs[0] = '{10'd0,   10'd52,  1'b1, 10'd9,  11'd10};
    vecs[1] = '{10'd104, 10'd52,  1'b1, 10'd11, 11'd12};
    vecs[2] = '{10'd467, 10'd52,  1'b1, 10'd17, 11'd18};
    vecs[3] = '{10'd468, 10'd52,  1'b0, 10'd0,  11'd0};
    vecs[4] = '{10'd51,  10'd100, 1'b1, 10'd9,  11'd10};
    vecs[5] = '{10'd500, 10'd52,  1'b0, 10'd0,  11'd0};
    vecs[6] = '{10'd0,   10'd467, 1'b1, 10'd72, 11'd10};
    vecs[7] = '{10'd0,   10'd468, 1'b0, 10'd0,  11'd0};

    rst = 1'b1; h_cnt = 10'd100; v_cnt = 10'd100;
    wr_req = 1'b0; wr_index = '0; wr_number = '0;
    tick(); tick();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_in_grid", in_grid, 0);
    chk("rst_index", index, 0);
    chk("rst_number", number, 0);
    chk("rst_fetch_busy", fetch_busy, 0);
    chk("rst_state", fsm_state, 0);
    rst = 1'b0;

    // Before any fetch, in-grid pixels show number 0.
    show_pixel(104, 52, 1, 11, 0);

    // Line 51 hblank prefetches row 1 (cells 9..17, values 10..18).
    fetch_line(51, 9);
    for (int i = 0; i < 8; i++)
      show_pixel(vecs[i].h, vecs[i].v, vecs[i].exp_in, vecs[i].exp_idx, vecs[i].exp_num);

    // Frame wrap: line 524 prefetches row 0.
    fetch_line(524, 0);
    show_pixel(0, 0, 1, 0, 1);
    show_pixel(467, 467, 1, 80, 9);

    // Line 470: next line is outside the grid, no memory activity.
    tick(); h_cnt = 10'd639; v_cnt = 10'd470;
    tick(); h_cnt = 10'd640;
    for (int n = 0; n < 12; n++) begin
      tick();
      chk("nofetch_busy", fetch_busy, 0);
      chk("nofetch_we", mem_we, 0);
    end

    // Write cell 40 <- 5, then fetch row 4 (line 208) and view cell 40.
    do_write(40, 5, 1);
    fetch_line(207, 36);
    show_pixel(208, 208, 1, 40, 5);
    show_pixel(156, 208, 1, 39, 40);

    // Write arriving together with a trigger waits for the whole fetch.
    tick(); h_cnt = 10'd639; v_cnt = 10'd51;
    tick(); h_cnt = 10'd640; wr_req = 1'b1; wr_index = 7'd3; wr_number = 11'd7;
    for (int n = 1; n <= 11; n++) begin
      tick();
      chk($sformatf("coll_no_ack t%0d", n), wr_ack, 0);
      if (n <= 9) chk($sformatf("coll_addr t%0d", n), mem_addr, 9 + n - 1);
    end
    tick();
    chk("coll_ack_t12", wr_ack, 1);
    chk("coll_we_t12", mem_we, 1);
    chk("coll_addr_t12", mem_addr, 3);
    tick(); wr_req = 1'b0;
    chk("coll_ack_drop", wr_ack, 0);

    // Out-of-range index is acknowledged without a RAM write.
    do_write(81, 9, 0);

    // Reset while FETCH is issuing k=4.
    tick(); h_cnt = 10'd639; v_cnt = 10'd51;
    tick(); h_cnt = 10'd640;
    for (int n = 0; n < 5; n++) tick();
    chk("midrst_k4_addr", mem_addr, 13);
    rst = 1'b1;
    tick();
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_wr_ack", wr_ack, 0);
    chk("midrst_fetch_busy", fetch_busy, 0);
    chk("midrst_index", index, 0);
    chk("midrst_number", number, 0);
    chk("midrst_state", fsm_state, 0);
    rst = 1'b0; h_cnt = 10'd104; v_cnt = 10'd52;
    tick();
    chk("postrst_in_grid", in_grid, 1);
    chk("postrst_index", index, 11);
    chk("postrst_number", number, 0);
    chk("postrst_idle_busy", fetch_busy, 0);
    fetch_line(51, 9);
    show_pixel(104, 52, 1, 11, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
